// File: rtl/time_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : time_keeper
//  Description : Time-of-day counter. Prescales the board clock to a 1 Hz
//                tick, keeps binary hours/minutes/seconds and lets the user
//                adjust each field with inc/dec pulses while in SET state.
//  Revision    : 1.0  initial release
// ============================================================================
module time_keeper #(
    parameter int CLK_FREQ = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_mode,
    input  logic [1:0] sel,
    input  logic       inc,
    input  logic       dec,
    output logic [6:0] hour,
    output logic [6:0] min,
    output logic [6:0] sec,
    output logic       sec_tick,
    output logic       hour_pulse,
    output logic       setting
);

    localparam int                c_PRE_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [c_PRE_W-1:0] c_TC   = c_PRE_W'(CLK_FREQ - 1);
    localparam logic [6:0]        c_MAX_MS = 7'd59;
    localparam logic [6:0]        c_MAX_H  = 7'd23;

    localparam logic [0:0] c_S_RUN = 1'b0;
    localparam logic [0:0] c_S_SET = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_PRE_W-1:0] r_pre;
    logic [6:0]         r_hour;
    logic [6:0]         r_min;
    logic [6:0]         r_sec;
    logic               r_sec_tick;
    logic               r_hour_pulse;
    logic               w_tc;
    logic               w_up;
    logic               w_dn;

    // Wrap-around adjust within one field; compare first so the result
    // never leaves 0..max, even for one cycle.
    function automatic logic [6:0] f_inc(input logic [6:0] v, input logic [6:0] max);
        return (v >= max) ? 7'd0 : v + 7'd1;
    endfunction

    function automatic logic [6:0] f_dec(input logic [6:0] v, input logic [6:0] max);
        return (v == 7'd0) ? max : v - 7'd1;
    endfunction

    // State register: RUN / SET
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_S_RUN;
        else     r_state <= w_state_nxt;
    end

    // Next state follows the requested mode level
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_RUN: if (set_mode)  w_state_nxt = c_S_SET;
            c_S_SET: if (!set_mode) w_state_nxt = c_S_RUN;
            default:                w_state_nxt = c_S_RUN;
        endcase
    end

    // Per-state control decode: terminal count only counts in RUN, and
    // adjustments only in SET with exactly one of inc/dec asserted
    always_comb begin
        w_tc = 1'b0;
        w_up = 1'b0;
        w_dn = 1'b0;
        case (r_state)
            c_S_RUN: w_tc = (r_pre == c_TC);
            c_S_SET: begin
                w_up = inc & ~dec;
                w_dn = dec & ~inc;
            end
            default: ;
        endcase
    end

    // Prescaler: held at 0 in SET and cleared on the edge that enters SET,
    // so the first second after returning to RUN is a full period
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pre <= '0;
        else if (r_state == c_S_SET || w_state_nxt == c_S_SET || w_tc)
            r_pre <= '0;
        else
            r_pre <= r_pre + c_PRE_W'(1);
    end

    // Time fields and event pulses; set adjustments never carry or pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hour       <= 7'd0;
            r_min        <= 7'd0;
            r_sec        <= 7'd0;
            r_sec_tick   <= 1'b0;
            r_hour_pulse <= 1'b0;
        end else begin
            r_sec_tick   <= 1'b0;
            r_hour_pulse <= 1'b0;
            if (w_tc) begin
                r_sec_tick <= 1'b1;
                r_sec      <= f_inc(r_sec, c_MAX_MS);
                if (r_sec == c_MAX_MS) begin
                    r_min <= f_inc(r_min, c_MAX_MS);
                    if (r_min == c_MAX_MS) begin
                        r_hour       <= f_inc(r_hour, c_MAX_H);
                        r_hour_pulse <= 1'b1;
                    end
                end
            end else if (w_up || w_dn) begin
                case (sel)
                    2'd0: r_sec  <= w_up ? f_inc(r_sec, c_MAX_MS)  : f_dec(r_sec, c_MAX_MS);
                    2'd1: r_min  <= w_up ? f_inc(r_min, c_MAX_MS)  : f_dec(r_min, c_MAX_MS);
                    2'd2: r_hour <= w_up ? f_inc(r_hour, c_MAX_H)  : f_dec(r_hour, c_MAX_H);
                    default: ;
                endcase
            end
        end
    end

    assign hour       = r_hour;
    assign min        = r_min;
    assign sec        = r_sec;
    assign sec_tick   = r_sec_tick;
    assign hour_pulse = r_hour_pulse;
    assign setting    = (r_state == c_S_SET);

endmodule
`default_nettype wire

// File: tb/tb_time_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_keeper
//  Description : Self-checking bench for time_keeper with a time-of-day
//                reference model (seconds since midnight) and random stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_time_keeper;

    localparam int CLK_FREQ = 4;

    logic       clk;
    logic       rst;
    logic       set_mode;
    logic [1:0] sel;
    logic       inc;
    logic       dec;
    logic [6:0] hour;
    logic [6:0] min;
    logic [6:0] sec;
    logic       sec_tick;
    logic       hour_pulse;
    logic       setting;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_tod   = 0;
    int m_phase = 0;
    bit m_set   = 0;
    bit m_tick  = 0;
    bit m_hp    = 0;

    time_keeper #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .set_mode  (set_mode),
        .sel       (sel),
        .inc       (inc),
        .dec       (dec),
        .hour      (hour),
        .min       (min),
        .sec       (sec),
        .sec_tick  (sec_tick),
        .hour_pulse(hour_pulse),
        .setting   (setting)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fld(input int lo_div, input int modv);
        return (m_tod / lo_div) % modv;
    endfunction

    // Advance the model by one clock edge using the inputs seen at that edge
    task automatic model_edge();
        int h, m, s, d;
        m_tick = 0;
        m_hp   = 0;
        if (!m_set) begin
            if (m_phase == CLK_FREQ - 1) begin
                m_tod   = (m_tod + 1) % 86400;
                m_tick  = 1;
                m_hp    = (m_tod % 3600 == 0);
                m_phase = 0;
            end else begin
                m_phase++;
            end
            if (set_mode) m_phase = 0;
        end else begin
            m_phase = 0;
            if (inc != dec) begin
                d = inc ? 1 : -1;
                h = m_tod / 3600;
                m = (m_tod / 60) % 60;
                s = m_tod % 60;
                case (sel)
                    2'd0: s = (s + d + 60) % 60;
                    2'd1: m = (m + d + 60) % 60;
                    2'd2: h = (h + d + 24) % 24;
                    default: ;
                endcase
                m_tod = h * 3600 + m * 60 + s;
            end
        end
        m_set = set_mode;
    endtask

    task automatic compare();
        chk("hour", int'(hour), fld(3600, 24));
        chk("min", int'(min), fld(60, 60));
        chk("sec", int'(sec), fld(1, 60));
        chk("sec_tick", int'(sec_tick), int'(m_tick));
        chk("hour_pulse", int'(hour_pulse), int'(m_hp));
        chk("setting", int'(setting), int'(m_set));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic pulse(input logic [1:0] s, input logic i, input logic d);
        sel = s;
        inc = i;
        dec = d;
        step();
        inc = 1'b0;
        dec = 1'b0;
    endtask

    // Assert reset between edges and check outputs clear without a clock edge
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("arst_hour", int'(hour), 0);
        chk("arst_min", int'(min), 0);
        chk("arst_sec", int'(sec), 0);
        chk("arst_setting", int'(setting), 0);
        chk("arst_tick", int'(sec_tick), 0);
        m_tod = 0; m_phase = 0; m_set = 0; m_tick = 0; m_hp = 0;
        #2 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; set_mode = 1'b0; sel = 2'd0; inc = 1'b0; dec = 1'b0;
        #8;
        chk("rst_hour", int'(hour), 0);
        chk("rst_sec", int'(sec), 0);
        chk("rst_setting", int'(setting), 0);
        #4 rst = 1'b0;

        // Count from reset: ticks exactly at cycles 4, 8, 12
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("tick_c%0d", k), int'(sec_tick), (k % 4 == 0) ? 1 : 0);
        end
        chk("pin_sec3", int'(sec), 3);
        chk("pin_min0", int'(min), 0);

        // Dial to 23:59:59 using decrements that wrap within each field
        set_mode = 1'b1;
        step();
        chk("pin_setting", int'(setting), 1);
        pulse(2'd2, 1'b0, 1'b1);
        chk("pin_hour23", int'(hour), 23);
        chk("pin_min_keep", int'(min), 0);
        pulse(2'd1, 1'b0, 1'b1);
        chk("pin_min59", int'(min), 59);
        chk("pin_hour_keep", int'(hour), 23);
        for (int k = 0; k < 4; k++) pulse(2'd0, 1'b0, 1'b1);
        chk("pin_sec59", int'(sec), 59);
        chk("pin_min_keep2", int'(min), 59);

        // Ignored inputs in SET, and no ticks while setting
        pulse(2'd0, 1'b1, 1'b1);
        chk("pin_both", int'(sec), 59);
        pulse(2'd3, 1'b1, 1'b0);
        chk("pin_sel3", int'(sec), 59);
        for (int k = 0; k < 20; k++) begin
            step();
            chk("set_notick", int'(sec_tick), 0);
        end

        // Full rollover 23:59:59 -> 00:00:00
        set_mode = 1'b0;
        step();
        for (int k = 0; k < 3; k++) step();
        chk("roll_pre_tick", int'(sec_tick), 0);
        step();
        chk("roll_hour", int'(hour), 0);
        chk("roll_min", int'(min), 0);
        chk("roll_sec", int'(sec), 0);
        chk("roll_tick", int'(sec_tick), 1);
        chk("roll_hp", int'(hour_pulse), 1);

        // Wrap without carry, then 00:59:59 -> 01:00:00
        set_mode = 1'b1;
        step();
        pulse(2'd2, 1'b0, 1'b1);
        pulse(2'd2, 1'b1, 1'b0);
        chk("wrap_hour0", int'(hour), 0);
        pulse(2'd1, 1'b0, 1'b1);
        pulse(2'd0, 1'b0, 1'b1);
        pulse(2'd0, 1'b1, 1'b0);
        chk("wrap_sec0", int'(sec), 0);
        chk("wrap_min59", int'(min), 59);
        pulse(2'd0, 1'b0, 1'b1);
        set_mode = 1'b0;
        step();
        for (int k = 0; k < 4; k++) step();
        chk("hr_hour1", int'(hour), 1);
        chk("hr_hp", int'(hour_pulse), 1);

        // inc in RUN is ignored
        pulse(2'd0, 1'b1, 1'b0);
        chk("run_inc", int'(sec), 0);

        // set_mode rises in the terminal-count cycle
        step(); step();
        set_mode = 1'b1;
        step();
        chk("coll_tick", int'(sec_tick), 1);
        chk("coll_sec", int'(sec), 1);
        chk("coll_setting", int'(setting), 1);
        set_mode = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("coll_notick", int'(sec_tick), 0);
        end
        step();
        chk("coll_full", int'(sec_tick), 1);

        // Async reset mid-second
        step(); step();
        async_reset();
        for (int k = 0; k < 4; k++) step();
        chk("arst_restart", int'(sec), 1);

        // Randomized operation
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) set_mode = ~set_mode;
            sel = 2'($urandom_range(0, 3));
            inc = ($urandom_range(0, 3) == 0);
            dec = ($urandom_range(0, 3) == 0);
            step();
            if (k == 1500) begin
                set_mode = 1'b0;
                inc = 1'b0;
                dec = 1'b0;
                async_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
